// File: rtl/cla_slice_sequencer_if.sv
// Start/ready/done handshake and result bus between the control unit and the
// multi-cycle slice adder.
interface cla_slice_sequencer_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output start, sub, a, b,
    input  ready, busy, done, sum, cout, ovf, zero
  );

  modport slave (
    input  start, sub, a, b,
    output ready, busy, done, sum, cout, ovf, zero
  );
endinterface

// File: rtl/cla_slice_sequencer.sv
// Area-reduced WIDTH-bit add/subtract: one 4-bit carry-lookahead slice reused
// once per nibble, LSB first, with the carry held in a register between passes.
module cla_slice_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  cla_slice_sequencer_if.slave   bus
);
  localparam int unsigned N     = WIDTH / 4;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned MSB   = WIDTH - 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             done_q;
  logic             cout_q;
  logic             ovf_q;
  logic             zero_q;

  logic             accept;
  logic [3:0]       sl_a;
  logic [3:0]       sl_b;
  logic [3:0]       sl_p;
  logic [3:0]       sl_g;
  logic [4:0]       sl_c;
  logic [3:0]       sl_s;
  logic [WIDTH-1:0] sum_nx;

  // start is honoured in IDLE and DONE only; RUN ignores it entirely
  assign accept = bus.start && (state != RUN);

  // Select the current nibble of each operand
  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (cnt == CNT_W'(i)) begin
        sl_a = opa[4*i +: 4];
        sl_b = opb[4*i +: 4];
      end
    end
  end

  // 4-bit carry-lookahead slice; group P/G outputs are not needed here
  always_comb begin
    sl_p    = sl_a ^ sl_b;
    sl_g    = sl_a & sl_b;
    sl_c[0] = carry;
    sl_c[1] = sl_g[0] | (sl_p[0] & sl_c[0]);
    sl_c[2] = sl_g[1] | (sl_p[1] & sl_g[0]) | (sl_p[1] & sl_p[0] & sl_c[0]);
    sl_c[3] = sl_g[2] | (sl_p[2] & sl_g[1]) | (sl_p[2] & sl_p[1] & sl_g[0])
            | (sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
    sl_c[4] = sl_g[3] | (sl_p[3] & sl_g[2]) | (sl_p[3] & sl_p[2] & sl_g[1])
            | (sl_p[3] & sl_p[2] & sl_p[1] & sl_g[0])
            | (sl_p[3] & sl_p[2] & sl_p[1] & sl_p[0] & sl_c[0]);
    sl_s    = sl_p ^ sl_c[3:0];
  end

  // Result with the current nibble merged in; complete on the last pass
  always_comb begin
    sum_nx = sum_q;
    for (int i = 0; i < int'(N); i++) begin
      if (cnt == CNT_W'(i)) sum_nx[4*i +: 4] = sl_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      opa    <= '0;
      opb    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      done_q <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // Subtraction is A + ~B + 1: invert B here, inject the +1 as carry-in
      if (accept) begin
        opa   <= bus.a;
        opb   <= bus.b ^ {WIDTH{bus.sub}};
        carry <= bus.sub;
        cnt   <= '0;
      end
      case (state)
        IDLE: if (bus.start) state <= RUN;
        RUN: begin
          sum_q <= sum_nx;
          carry <= sl_c[4];
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state  <= DONE;
            done_q <= 1'b1;
            cout_q <= sl_c[4];
            ovf_q  <= (opa[MSB] == opb[MSB]) && (sum_nx[MSB] != opa[MSB]);
            zero_q <= (sum_nx == '0);
          end
        end
        DONE:    state <= bus.start ? RUN : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ready = (state != RUN);
  assign bus.busy  = (state == RUN);
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign bus.ovf   = ovf_q;
  assign bus.zero  = zero_q;
endmodule

// File: tb/tb_cla_slice_sequencer.sv
// Bench for cla_slice_sequencer: directed literal cases plus randomized
// operations compared every cycle against an arithmetic reference model.
module tb_cla_slice_sequencer;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned N     = WIDTH / 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  bit   chk_en;

  cla_slice_sequencer_if #(.WIDTH(WIDTH)) bus ();

  cla_slice_sequencer #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Reference: plain wide arithmetic; overflow when the true signed result
  // does not survive truncation to WIDTH bits.
  function automatic void ref_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] r, output logic co,
                                 output logic ov, output logic z);
    longint    sa;
    longint    sb;
    longint    sr;
    logic [32:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      u  = {1'b0, a} - {1'b0, b};
      co = ~u[32];
      sr = sa - sb;
    end else begin
      u  = {1'b0, a} + {1'b0, b};
      co = u[32];
      sr = sa + sb;
    end
    r  = u[31:0];
    ov = (sr != longint'($signed(r)));
    z  = (r == 32'h0);
  endfunction

  // Model: busy for N cycles after an accepted start, then one done cycle
  bit          m_run;
  int          m_left;
  bit          m_done;
  logic [31:0] m_sum;
  logic        m_cout;
  logic        m_ovf;
  logic        m_zero;
  logic [31:0] p_sum;
  logic        p_cout;
  logic        p_ovf;
  logic        p_zero;

  always @(posedge clk) begin
    if (rst) begin
      m_run = 0; m_left = 0; m_done = 0;
      m_sum = '0; m_cout = 0; m_ovf = 0; m_zero = 0;
    end else begin
      m_done = 0;
      if (m_run) begin
        m_left--;
        if (m_left == 0) begin
          m_run = 0; m_done = 1;
          m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf; m_zero = p_zero;
        end
      end else if (bus.start) begin
        ref_op(bus.a, bus.b, bus.sub, p_sum, p_cout, p_ovf, p_zero);
        m_run  = 1;
        m_left = N;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk1("ready", bus.ready, !m_run);
      chk1("busy", bus.busy, m_run);
      chk1("done", bus.done, m_done);
      if (!m_run) begin
        chk32("sum", bus.sum, m_sum);
        chk1("cout", bus.cout, m_cout);
        chk1("ovf", bus.ovf, m_ovf);
        chk1("zero", bus.zero, m_zero);
      end
    end
  end

  // Issue one op from the current negedge; optionally pulse start at RUN cycle inj_at
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic ts,
                        input int inj_at, input bit rnd_noise, output int lat);
    int k;
    bus.start = 1'b1; bus.a = ta; bus.b = tb_v; bus.sub = ts;
    @(negedge clk);
    bus.start = 1'b0; bus.a = $urandom; bus.b = $urandom; bus.sub = 1'($urandom_range(0, 1));
    k = 1;
    while (!bus.done && k < 20) begin
      if (k == inj_at) begin
        bus.start = 1'b1; bus.a = 32'h1; bus.b = 32'h1; bus.sub = 1'b0;
      end else if (rnd_noise && $urandom_range(0, 3) == 0) begin
        bus.start = 1'b1; bus.a = $urandom; bus.b = $urandom;
      end
      @(negedge clk);
      bus.start = 1'b0;
      k++;
    end
    lat = k;
  endtask

  task automatic directed(input string name, input logic [31:0] ta, input logic [31:0] tb_v,
                          input logic ts, input int inj_at, input logic [31:0] es,
                          input logic ec, input logic eo, input logic ez);
    int lat;
    run_op(ta, tb_v, ts, inj_at, 1'b0, lat);
    chk32({name, "_latency"}, 32'(lat), 32'(N + 1));
    chk32({name, "_sum"}, bus.sum, es);
    chk1({name, "_cout"}, bus.cout, ec);
    chk1({name, "_ovf"}, bus.ovf, eo);
    chk1({name, "_zero"}, bus.zero, ez);
    chk1({name, "_ready"}, bus.ready, 1'b1);
  endtask

  initial begin
    int lat;
    int k;
    logic [31:0] ra;
    logic [31:0] rb;
    checks = 0; failures = 0; chk_en = 0;
    rst = 1'b1; bus.start = 1'b0; bus.sub = 1'b0; bus.a = '0; bus.b = '0;
    repeat (2) @(negedge clk);
    chk1("rst_ready", bus.ready, 1'b1);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_done", bus.done, 1'b0);
    chk32("rst_sum", bus.sum, 32'h0);
    chk1("rst_cout", bus.cout, 1'b0);
    chk1("rst_ovf", bus.ovf, 1'b0);
    chk1("rst_zero", bus.zero, 1'b0);
    rst = 1'b0;
    chk_en = 1;
    @(negedge clk);

    directed("add_f_1", 32'h0000000F, 32'h00000001, 1'b0, -1, 32'h00000010, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    directed("add_ripple", 32'hFFFFFFFF, 32'h00000001, 1'b0, -1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    directed("add_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, -1, 32'h80000000, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    directed("sub_ovf", 32'h80000000, 32'h00000001, 1'b1, -1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    directed("sub_neg", 32'h00000005, 32'h00000007, 1'b1, -1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    directed("sub_zero", 32'h00000007, 32'h00000007, 1'b1, -1, 32'h00000000, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    directed("ignore_start", 32'h12345678, 32'h11111111, 1'b0, 3, 32'h23456789, 1'b0, 1'b0, 1'b0);
    // still in the DONE cycle: back-to-back start
    directed("b2b", 32'h00000001, 32'h00000002, 1'b0, -1, 32'h00000003, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Reset in the middle of RUN aborts with no done pulse
    bus.start = 1'b1; bus.a = 32'hDEADBEEF; bus.b = 32'h01020304; bus.sub = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    for (k = 1; k < 4; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk1("abort_ready", bus.ready, 1'b1);
    chk1("abort_busy", bus.busy, 1'b0);
    chk32("abort_sum", bus.sum, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk1("abort_no_done", bus.done, 1'b0);
    end

    // Randomized operations with corner operands, gaps and ignored starts
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0:       ra = 32'hFFFFFFFF;
        1:       ra = 32'h80000000;
        2:       ra = 32'h7FFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       rb = ra;
        1:       rb = 32'h00000001;
        2:       rb = 32'h80000000;
        default: rb = $urandom;
      endcase
      run_op(ra, rb, 1'($urandom_range(0, 1)), -1, 1'b1, lat);
      chk32("rand_latency", 32'(lat), 32'(N + 1));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        bus.a = $urandom; bus.b = $urandom;
      end
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
